lbm_stream_framer: RTL



---
 rtl/lbm_stream_framer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/lbm_stream_framer.sv
// AXI4-Stream output stage for LBM solver cell beats: small FIFO, regenerated per-frame tlast,
// upstream framing check and a completed-frame counter.
module lbm_stream_framer #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned FRAME_BEATS = 2500
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]       s_axis_tstrb,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  output logic                          m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]       m_axis_tstrb,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic [31:0]                   frame_count,
  output logic                          framing_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned StrbW  = DATA_WIDTH / 8;
  localparam int unsigned AddrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW   = AddrW + 1;
  localparam int unsigned IdxW   = $clog2(FRAME_BEATS);
  localparam int unsigned EntryW = StrbW + DATA_WIDTH;

  localparam logic [IdxW-1:0] LastIdx = IdxW'(FRAME_BEATS - 1);
  localparam logic [LvlW-1:0] FullLvl = LvlW'(FIFO_DEPTH);

  logic [EntryW-1:0] mem_q [FIFO_DEPTH];
  logic [EntryW-1:0] rd_entry;

  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic [IdxW-1:0]  in_idx_q, in_idx_d;
  logic [IdxW-1:0]  out_idx_q, out_idx_d;
  logic [31:0]      frame_count_q, frame_count_d;
  logic             framing_err_q, framing_err_d;

  logic push, pop, exp_last;

  // Flags come from the registered level only; rst masks both handshakes while asserted.
  assign s_axis_tready = !rst && (level_q != FullLvl);
  assign m_axis_tvalid = !rst && (level_q != '0);
  assign push          = s_axis_tvalid && s_axis_tready;
  assign pop           = m_axis_tvalid && m_axis_tready;

  assign rd_entry      = mem_q[rd_ptr_q];
  assign m_axis_tdata  = rd_entry[DATA_WIDTH-1:0];
  assign m_axis_tstrb  = rd_entry[EntryW-1 -: StrbW];
  assign m_axis_tlast  = m_axis_tvalid && (out_idx_q == LastIdx);

  assign exp_last      = (in_idx_q == LastIdx);

  assign frame_count   = frame_count_q;
  assign framing_err   = framing_err_q;
  assign fifo_level    = level_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {s_axis_tstrb, s_axis_tdata};
    end
  end

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    in_idx_d      = in_idx_q;
    out_idx_d     = out_idx_q;
    frame_count_d = frame_count_q;
    framing_err_d = framing_err_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (s_axis_tlast != exp_last) begin
        framing_err_d = 1'b1;
      end
      // Upstream tlast always resyncs the input counter, even when it was early.
      if (s_axis_tlast || exp_last) begin
        in_idx_d = '0;
      end else begin
        in_idx_d = in_idx_q + 1'b1;
      end
    end

    if (pop) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      out_idx_d = (out_idx_q == LastIdx) ? '0 : out_idx_q + 1'b1;
      if (m_axis_tlast) begin
        frame_count_d = frame_count_q + 32'd1;
      end
    end

    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      in_idx_q      <= '0;
      out_idx_q     <= '0;
      frame_count_q <= '0;
      framing_err_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      in_idx_q      <= in_idx_d;
      out_idx_q     <= out_idx_d;
      frame_count_q <= frame_count_d;
      framing_err_q <= framing_err_d;
    end
  end

`ifndef SYNTHESIS
  a_level_bound : assert property (@(posedge clk) disable iff (rst) level_q <= FullLvl);

  a_out_stable : assert property (@(posedge clk) disable iff (rst)
    (m_axis_tvalid && !m_axis_tready) |=>
      (m_axis_tvalid && $stable(m_axis_tdata) && $stable(m_axis_tstrb) && $stable(m_axis_tlast)));
`endif

endmodule
